neuron_row_mac: RTL
===================

# neuron_row_mac

Sequencing multiply-accumulate stage for one ANN neuron, directly downstream of a per-row weight BRAM (28 × 16-bit, read on the falling clock edge) and a matching 28-entry input-activation BRAM. On START it walks addresses 0–27 of both memories and multiplies each signed Q8.8 weight/input pair. It accumulates the products onto a bias, or onto the previous row's partial sum, and presents a Q8.8 result with a one-cycle DONE pulse. Rows of a 28×28 neuron are processed by chaining 28 successive runs.

## Interface
- ROW_LEN, 28: entries per row; address width is 5.
- ACC_W, 40: accumulator width, Q24.16 signed.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  begin a row pass; sampled only in IDLE.
- CHAIN  in  1  sampled with START: 1 keeps the accumulator, 0 loads the bias.
- BIAS  in  16  signed Q8.8; loaded as BIAS<<<8 when CHAIN=0.
- W_ADDR  out  5  weight BRAM address.
- W_EN  out  1  weight BRAM enable. The BRAM's WE is tied 0 at top level during inference.
- W_DO  in  16  weight BRAM read data, signed Q8.8.
- X_ADDR  out  5  input BRAM address; always equal to W_ADDR.
- X_EN  out  1  input BRAM enable; always equal to W_EN.
- X_DO  in  16  input BRAM read data, signed Q8.8.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  one-cycle pulse; RESULT is valid.
- RESULT  out  16  signed Q8.8; held until the next DONE.

## Operation
- States:
  - IDLE → ISSUE on START.
  - ISSUE (addresses 0..27 issued) → DRAIN after address 27.
  - DRAIN (2 cycles: last product, last accumulate) → FINISH.
  - FINISH (write RESULT, pulse DONE) → IDLE.
- Pipeline:
  - The address is registered on the rising edge.
  - The BRAM samples it on the falling edge; data is valid at the next rising edge.
  - PROD register = signed W_DO × X_DO, 32-bit Q16.16.
  - On the following edge, ACC += sign-extended PROD.
- Accumulator on START acceptance: CHAIN=0 loads sign-extended BIAS<<<8; CHAIN=1 leaves ACC unchanged.
- Result conversion: ACC >>> 8 (arithmetic shift, truncation toward −∞), then narrowed to 16 bits per the Configuration section.
- START outside IDLE is ignored; no queuing.
- W_EN/X_EN are high only during ISSUE. Addresses return to 0 outside ISSUE.
- Reset: state IDLE; ACC, PROD, RESULT = 0; BUSY, DONE, W_EN, X_EN = 0; addresses = 0.
- Reset during a pass aborts it: no DONE, and the partial sum is discarded.

## Timing
- START is high at edge T0. EN=1 with ADDR=0 from T0.
- ADDR=k from edge Tk, for k = 0..27. EN falls at T28.
- PROD(k) is captured at Tk+1. ACC includes PROD(k) at Tk+2.
- The final accumulate is at T29. RESULT is registered and DONE=1 at T30. BUSY falls at T30.
- Earliest next START is sampled at T31.
- Total START-to-DONE latency: 30 cycles.

## Configuration
- MAC_SAT_EN defined: RESULT saturates to 0x7FFF or 0x8000 when ACC>>>8 is outside the signed 16-bit range.
- MAC_SAT_EN undefined: RESULT = bits [23:8] of ACC (wrap). This saves the comparator logic.
- The accumulator itself never saturates in either mode. 40 bits covers 28 full-scale products plus the bias.

## Structure
- Package ann_pkg holds:
  - ROW_LEN, Q_FRAC (=8), data width 16, ACC_W.
  - The state encoding (IDLE, ISSUE, DRAIN, FINISH).
- Sub-module q88_narrow: combinational ACC → 16-bit Q8.8 conversion, containing the MAC_SAT_EN switch. It is shared with the later activation stage.

## Test plan
- Weights 0x0100, inputs 0x0100, BIAS 0, CHAIN 0 → DONE at T30, RESULT 0x1C00, BUSY high T1–T29.
- Weights 0, BIAS 0x0080, CHAIN 0 → RESULT 0x0080.
- Weights 0xFF00, inputs 0x0100, BIAS 0: first pass CHAIN 0 → 0xE400; second pass CHAIN 1 → 0xC800.
- Weights 0x4000, inputs 0x0100, BIAS 0 → 0x7FFF with MAC_SAT_EN; 0x0000 without.
- Assert RST at T10 of a pass → BUSY/DONE/EN 0 and RESULT 0 immediately. A following CHAIN=0 pass gives the correct value.
- START pulsed at T5 and T20 of an active pass → ignored; exactly one DONE at T30.

Source files
------------

// File: rtl/ann_pkg.sv
// Shared constants, FSM encoding and helpers for the ANN neuron datapath.
package ann_pkg;

    localparam int unsigned ROW_LEN = 28;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned Q_FRAC  = 8;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned PROD_W  = 2 * DATA_W;
    localparam int unsigned ACC_W   = 40;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StFinish
    } mac_state_e;

    // Q8.8 bias aligned to the Q24.16 accumulator (sign-extended, << Q_FRAC).
    function automatic logic [ACC_W-1:0] bias_to_acc(input logic [DATA_W-1:0] bias);
        return {{(ACC_W - DATA_W - Q_FRAC){bias[DATA_W-1]}}, bias, {Q_FRAC{1'b0}}};
    endfunction

    function automatic logic [ACC_W-1:0] prod_to_acc(input logic [PROD_W-1:0] prod);
        return {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    endfunction

endpackage

// File: rtl/q88_narrow.sv
// Q24.16 accumulator -> Q8.8 conversion (ACC >>> 8 narrowed to 16 bits).
// Define MAC_SAT_EN to saturate instead of wrapping.
module q88_narrow
    import ann_pkg::*;
(
    input  logic [ACC_W-1:0]  acc_i,
    output logic [DATA_W-1:0] q_o
);

    localparam int unsigned MsbIdx = Q_FRAC + DATA_W - 1;

`ifdef MAC_SAT_EN
    logic in_range;
    logic unused_frac;

    // In range when every bit above the result MSB matches its sign.
    assign in_range    = (&acc_i[ACC_W-1:MsbIdx]) | ~(|acc_i[ACC_W-1:MsbIdx]);
    assign unused_frac = ^acc_i[Q_FRAC-1:0];

    always_comb begin
        q_o = acc_i[MsbIdx:Q_FRAC];
        if (!in_range) begin
            q_o = acc_i[ACC_W-1] ? 16'h8000 : 16'h7FFF;
        end
    end
`else
    logic unused_bits;

    assign unused_bits = ^{acc_i[ACC_W-1:MsbIdx+1], acc_i[Q_FRAC-1:0]};
    assign q_o         = acc_i[MsbIdx:Q_FRAC];
`endif

endmodule

// File: rtl/neuron_row_mac.sv
// One-row sequencing MAC: walks 28 weight/input BRAM pairs, accumulates Q16.16
// products onto a bias or prior partial sum, emits a Q8.8 result with DONE.
module neuron_row_mac
    import ann_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              chain_i,
    input  logic [DATA_W-1:0] bias_i,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic              w_en_o,
    input  logic [DATA_W-1:0] w_do_i,
    output logic [ADDR_W-1:0] x_addr_o,
    output logic              x_en_o,
    input  logic [DATA_W-1:0] x_do_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(ROW_LEN - 1);

    mac_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [PROD_W-1:0]  prod_q;
    logic               prod_vld_q;
    logic [DATA_W-1:0]  result_q;
    logic               done_q;
    logic [DATA_W-1:0]  narrow_q88;
    logic               accept;

    assign accept = (state_q == StIdle) && start_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_i) state_d = StIssue;
            StIssue:  if (addr_q == LastAddr) state_d = StDrain;
            StDrain:  state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        w_en_o   = (state_q == StIssue);
        x_en_o   = (state_q == StIssue);
        w_addr_o = addr_q;
        x_addr_o = addr_q;
        busy_o   = (state_q != StIdle);
        done_o   = done_q;
        result_o = result_q;
    end

    always_comb begin
        addr_d = '0;
        if (state_q == StIssue && addr_q != LastAddr) begin
            addr_d = addr_q + 1'b1;
        end
    end

    // PROD lags the issued address by one edge, ACC by two.
    always_comb begin
        acc_d = acc_q;
        if (accept) begin
            if (!chain_i) acc_d = bias_to_acc(bias_i);
        end else if (prod_vld_q) begin
            acc_d = acc_q + prod_to_acc(prod_q);
        end
    end

    q88_narrow u_narrow (
        .acc_i (acc_q),
        .q_o   (narrow_q88)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            acc_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            result_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            acc_q      <= acc_d;
            prod_vld_q <= (state_q == StIssue);
            done_q     <= (state_q == StFinish);
            if (state_q == StIssue) begin
                prod_q <= $signed(w_do_i) * $signed(x_do_i);
            end
            if (state_q == StFinish) begin
                result_q <= narrow_q88;
            end
        end
    end

endmodule
